// File: rtl/matrix_mac_pkg.sv
// Shared definitions for the matrix MAC datapath.
// Lane geometry, group sizing and the feeder state encoding.
package matrix_mac_pkg;

    localparam int LANE_W           = 16;
    localparam int BEATS_PER_GRP    = 4;
    localparam int PACK_W           = 64;
    localparam int PARALLEL_NUM_DEF = 28;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_A,
        ISSUE,
        WAIT
    } state_t;

endpackage

// File: rtl/matrix_mac_feeder_if.sv
// Control, operand-stream and MAC-set signals of the matrix MAC feeder.
// master = job/operand source side, slave = the feeder itself.
interface matrix_mac_feeder_if
    import matrix_mac_pkg::*;
#(
    parameter int PARALLEL_NUM = PARALLEL_NUM_DEF,
    parameter int GRP_W        = 8
);

    localparam int VEC_W = PARALLEL_NUM * LANE_W;

    logic             start;
    logic [GRP_W-1:0] cfg_groups;
    logic [VEC_W-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [VEC_W-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [VEC_W-1:0] mulaSet;
    logic [VEC_W-1:0] mulbSet;
    logic [PACK_W-1:0] addcSet;
    logic             mulabSet_val;
    logic             macabSet_val;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, cfg_groups, a_data, a_valid,
        output b_data, b_valid, macabSet_val,
        input  a_ready, b_ready, mulaSet, mulbSet,
        input  addcSet, mulabSet_val, busy, done, err
    );

    modport slave (
        input  start, cfg_groups, a_data, a_valid,
        input  b_data, b_valid, macabSet_val,
        output a_ready, b_ready, mulaSet, mulbSet,
        output addcSet, mulabSet_val, busy, done, err
    );

endinterface

// File: rtl/matrix_mac_feeder.sv
// Operand issuer for the dot-product MAC set: one A row, streamed B columns
// in groups of four beats, with return counting and completion signalling.
module matrix_mac_feeder
    import matrix_mac_pkg::*;
#(
    parameter int PARALLEL_NUM = PARALLEL_NUM_DEF,
    parameter int GRP_W        = 8
) (
    input logic                clk,
    input logic                rstn,
    matrix_mac_feeder_if.slave bus
);

    localparam int VEC_W = PARALLEL_NUM * LANE_W;
    localparam int BW    = $clog2(BEATS_PER_GRP);

    state_t           state;
    logic [GRP_W-1:0] groups;
    logic [GRP_W-1:0] grp_issued;
    logic [GRP_W-1:0] grp_ret;
    logic [BW-1:0]    beat_cnt;
    logic [VEC_W-1:0] mula_q;
    logic [VEC_W-1:0] mulb_q;
    logic             a_rdy_q;
    logic             b_rdy_q;
    logic             val_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             a_xfer;
    logic             b_xfer;
    logic             grp_end;
    logic             last_beat;
    logic             ret_ok;
    logic [GRP_W-1:0] ret_nxt;

    assign a_xfer    = bus.a_valid & a_rdy_q;
    assign b_xfer    = bus.b_valid & b_rdy_q;
    assign grp_end   = beat_cnt == BW'(BEATS_PER_GRP - 1);
    assign last_beat = b_xfer && grp_end
                       && (grp_issued == groups - 1'b1);

    // A return is only legal while a job is issuing/waiting and not yet full.
    assign ret_ok  = (state == ISSUE || state == WAIT)
                     && (grp_ret != groups);
    assign ret_nxt = grp_ret
                     + GRP_W'(bus.macabSet_val && ret_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            groups     <= '0;
            grp_issued <= '0;
            grp_ret    <= '0;
            beat_cnt   <= '0;
            mula_q     <= '0;
            mulb_q     <= '0;
            a_rdy_q    <= 1'b0;
            b_rdy_q    <= 1'b0;
            val_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            val_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_q <= 1'b0;
                        if (bus.cfg_groups != '0) begin
                            groups     <= bus.cfg_groups;
                            grp_issued <= '0;
                            grp_ret    <= '0;
                            beat_cnt   <= '0;
                            busy_q     <= 1'b1;
                            a_rdy_q    <= 1'b1;
                            state      <= LOAD_A;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    if (a_xfer) begin
                        mula_q  <= bus.a_data;
                        a_rdy_q <= 1'b0;
                        b_rdy_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (b_xfer) begin
                        mulb_q   <= bus.b_data;
                        val_q    <= 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (grp_end) begin
                            grp_issued <= grp_issued + 1'b1;
                        end
                        if (last_beat) begin
                            b_rdy_q <= 1'b0;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (ret_nxt == groups) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed after the case so a spurious return beats the start clear.
            if (bus.macabSet_val) begin
                if (ret_ok) begin
                    grp_ret <= ret_nxt;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.mulaSet      = mula_q;
    assign bus.mulbSet      = mulb_q;
    assign bus.addcSet      = '0;
    assign bus.mulabSet_val = val_q;
    assign bus.a_ready      = a_rdy_q;
    assign bus.b_ready      = b_rdy_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;

endmodule
